apb_slave_mem: RTL and testbench

- Word-addressed APB3 completer (slave) memory; the consumer of the APB bus driven through APB_intf.
- Connects directly to the interface signals. Consumes PSEL1/PENABLE/PWRITE/PADDR/PWDATA and produces PRDATA/PREADY/PSLVERR.
- Produces bus behaviour that satisfies the interface's four protocol assertions. Optional programmable wait states exercise the PREADY-low path.

---
 rtl/apb_slave_mem.sv | 187 ++++++++++++++++++
 tb/tb_apb_slave_mem.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// apb_slave_mem : word-addressed APB3 completer memory with registered outputs.
// Optional wait states are enabled by defining APB_SLV_WAIT_EN.
// Revision      : 1.0
// ============================================================================
module apb_slave_mem #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        PRESETn,
    input  logic        PSEL1,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int          c_IDXW = $clog2(DEPTH);
    localparam logic [31:0] c_SPAN = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_prdata;
    logic [31:0]       w_prdata_nxt;
    logic              r_pready;
    logic              w_pready_nxt;
    logic              r_pslverr;
    logic              w_pslverr_nxt;
    logic              r_write;
    logic              r_err;
    logic [c_IDXW-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic              w_latch;
    logic              w_mem_we;
    logic              w_go_wait;

    // 33-bit offset: bit 32 flags addresses below BASE_ADDR without a
    // separate magnitude compare.
    logic [32:0]       w_diff;
    logic              w_err;
    logic [c_IDXW-1:0] w_idx;

    assign w_diff = {1'b0, PADDR} - {1'b0, BASE_ADDR};
    assign w_err  = (w_diff[1:0] != 2'b00) | w_diff[32] | (w_diff[31:0] >= c_SPAN);
    assign w_idx  = w_diff[c_IDXW+1:2];

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    assign w_go_wait = (c_WAIT != 4'd0);

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    logic [3:0] w_unused_wait;

    assign w_unused_wait = 4'(WAIT_CYCLES);
    assign w_go_wait     = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;
        w_latch       = 1'b0;
        w_mem_we      = 1'b0;
`ifdef APB_SLV_WAIT_EN
        w_cnt_nxt     = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (PSEL1 && !PENABLE) begin
                    w_latch = 1'b1;
                    if (w_go_wait) begin
                        w_state_nxt = S_WAIT;
`ifdef APB_SLV_WAIT_EN
                        w_cnt_nxt   = c_WAIT;
`endif
                    end else begin
                        w_state_nxt   = S_READY;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_err;
                        w_prdata_nxt  = (!PWRITE && !w_err) ? r_mem[w_idx] : 32'd0;
                    end
                end
            end
`ifdef APB_SLV_WAIT_EN
            S_WAIT: begin
                if (!PSEL1) begin
                    w_state_nxt = S_IDLE;
                end else if (PENABLE) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt   = S_READY;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = r_err;
                        w_prdata_nxt  = (!r_write && !r_err) ? r_mem[r_idx] : 32'd0;
                    end
                end
            end
`endif
            S_READY: begin
                if (!PSEL1) begin
                    w_state_nxt   = S_IDLE;
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = 32'd0;
                end else if (PENABLE) begin
                    w_mem_we      = r_write && !r_err;
                    w_state_nxt   = S_IDLE;
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = 32'd0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
                w_prdata_nxt  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_prdata  <= 32'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            if (w_latch) begin
                r_write <= PWRITE;
                r_err   <= w_err;
                r_idx   <= w_idx;
                r_wdata <= PWDATA;
            end
        end
    end

    // Memory is written only on the completion edge, from the latched setup values.
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// tb_apb_slave_mem : directed self-checking bench for apb_slave_mem.
// Revision         : 1.0
// ============================================================================
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
    localparam int c_W = 2;
`else
    localparam int c_W = 0;
`endif

    logic        clk;
    logic        PRESETn;
    logic        PSEL1;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_vec = 0;
    int n_err = 0;

    apb_slave_mem #(
        .DEPTH       (64),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) u_dut (
        .clk     (clk),
        .PRESETn (PRESETn),
        .PSEL1   (PSEL1),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PSEL1   = 1'b0;
        PENABLE = 1'b0;
        tick();
    endtask

    // Full transfer; returns one ns after the completion edge so a new
    // setup can follow immediately.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        PSEL1   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        tick();
        PENABLE = 1'b1;
        for (int n = 0; n < c_W; n++) begin
            chk("pready_wait", {31'd0, PREADY}, 32'd0);
            tick();
        end
        chk("pready", {31'd0, PREADY}, 32'd1);
        chk("pslverr", {31'd0, PSLVERR}, {31'd0, exp_err});
        chk("prdata", PRDATA, exp_rd);
        tick();
        chk("pready_done", {31'd0, PREADY}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0;
        PSEL1   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'd0;
        PWDATA  = 32'd0;
        repeat (3) tick();
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pready", {31'd0, PREADY}, 32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        PRESETn = 1'b1;
        tick();

        // Zero-wait (or waited) write then read-after-write, back to back
        xfer(1'b1, 32'h08, 32'h1234_5678, 32'd0, 1'b0);
        xfer(1'b0, 32'h08, 32'd0, 32'h1234_5678, 1'b0);
        xfer(1'b1, 32'h10, 32'h5555_5555, 32'd0, 1'b0);
        xfer(1'b0, 32'h10, 32'd0, 32'h5555_5555, 1'b0);
        idle();

        // Reset asserted during the access phase of a write
        PSEL1   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h10;
        PWDATA  = 32'hDEAD_BEEF;
        tick();
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        #1;
        chk("midrst_prdata", PRDATA, 32'd0);
        chk("midrst_pready", {31'd0, PREADY}, 32'd0);
        chk("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
        PSEL1   = 1'b0;
        PENABLE = 1'b0;
        tick();
        chk("inrst_pready", {31'd0, PREADY}, 32'd0);
        PRESETn = 1'b1;
        tick();
        xfer(1'b0, 32'h10, 32'd0, 32'd0, 1'b0);
        xfer(1'b0, 32'h08, 32'd0, 32'd0, 1'b0);
        idle();

        // Errors: misaligned, out of range, misaligned in range
        xfer(1'b1, 32'h102, 32'hFFFF_FFFF, 32'd0, 1'b1);
        xfer(1'b1, 32'h100, 32'hFFFF_FFFF, 32'd0, 1'b1);
        xfer(1'b1, 32'h002, 32'hFFFF_FFFF, 32'd0, 1'b1);
        xfer(1'b0, 32'h100, 32'd0, 32'd0, 1'b1);
        xfer(1'b0, 32'h000, 32'd0, 32'd0, 1'b0);
        idle();

        // Back-to-back with no idle cycles
        xfer(1'b1, 32'h0, 32'h11, 32'd0, 1'b0);
        xfer(1'b1, 32'h4, 32'h22, 32'd0, 1'b0);
        xfer(1'b0, 32'h0, 32'd0, 32'h11, 1'b0);
        xfer(1'b0, 32'h4, 32'd0, 32'h22, 1'b0);
        idle();

        // PENABLE without a setup is ignored
        PSEL1   = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b0;
        PADDR   = 32'h4;
        tick();
        chk("noset_pready", {31'd0, PREADY}, 32'd0);
        tick();
        chk("noset_pready2", {31'd0, PREADY}, 32'd0);
        xfer(1'b0, 32'h4, 32'd0, 32'h22, 1'b0);
        idle();

        // Last word boundary
        xfer(1'b1, 32'hFC, 32'hCAFE_F00D, 32'd0, 1'b0);
        xfer(1'b0, 32'hFC, 32'd0, 32'hCAFE_F00D, 1'b0);
        idle();

        // Bus changes after setup must not alter the transfer
        PSEL1   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h20;
        PWDATA  = 32'h0BAD_F00D;
        tick();
        PENABLE = 1'b1;
        PADDR   = 32'h24;
        PWDATA  = 32'd0;
        for (int n = 0; n < c_W; n++) tick();
        chk("latch_pready", {31'd0, PREADY}, 32'd1);
        tick();
        idle();
        xfer(1'b0, 32'h20, 32'd0, 32'h0BAD_F00D, 1'b0);
        xfer(1'b0, 32'h24, 32'd0, 32'd0, 1'b0);
        idle();

        // Abort: PSEL1 dropped before completion, no write may occur
        PSEL1   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'hC;
        PWDATA  = 32'hAA;
        tick();
`ifdef APB_SLV_WAIT_EN
        PENABLE = 1'b1;
        chk("abort_pready0", {31'd0, PREADY}, 32'd0);
        tick();
        chk("abort_pready1", {31'd0, PREADY}, 32'd0);
`else
        chk("abort_ready", {31'd0, PREADY}, 32'd1);
`endif
        PSEL1   = 1'b0;
        PENABLE = 1'b0;
        tick();
        chk("abort_pready2", {31'd0, PREADY}, 32'd0);
        tick();
        chk("abort_pready3", {31'd0, PREADY}, 32'd0);
        xfer(1'b0, 32'hC, 32'd0, 32'd0, 1'b0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
